// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types for the burst_ram arbiter: FSM state encoding and command values.
package burst_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BURST = 2'd1,
    READ_BURST  = 2'd2
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above the
// pointer, wrapping around.
module rr_picker #(
  parameter int NumRequesters = 2,
  parameter int IdxW          = $clog2(NumRequesters)
) (
  input  logic [NumRequesters-1:0] req_i,
  input  logic [IdxW-1:0]          ptr_i,
  output logic [IdxW-1:0]          winner_o,
  output logic                     any_valid_o
);

  int idx;

  // Scan farthest-from-pointer first so the closest requester is assigned last.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NumRequesters;
      if (req_i[idx]) begin
        winner_o    = IdxW'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one burst_ram among several masters; the grant is
// held for a whole read or write burst.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int NumRequesters   = 2,
  parameter int AddressBitWidth = 4,
  parameter int BurstDataCount  = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NumRequesters-1:0]                       req_cmd,
  input  logic [NumRequesters-1:0]                       req_cmd_en,
  input  logic [NumRequesters-1:0][AddressBitWidth-1:0]  req_addr,
  input  logic [NumRequesters-1:0][63:0]                 req_wr_data,
  input  logic [NumRequesters-1:0][7:0]                  req_data_mask,
  output logic [NumRequesters-1:0]                       req_busy,
  output logic [63:0]                                    req_rd_data,
  output logic [NumRequesters-1:0]                       req_rd_data_valid,
  output logic [NumRequesters-1:0]                       grant,
  output logic                                           br_cmd,
  output logic                                           br_cmd_en,
  output logic [AddressBitWidth-1:0]                     br_addr,
  output logic [63:0]                                    br_wr_data,
  output logic [7:0]                                     br_data_mask,
  input  logic [63:0]                                    br_rd_data,
  input  logic                                           br_rd_data_valid,
  input  logic                                           br_busy
);

  localparam int IdxW = $clog2(NumRequesters);
  localparam int CntW = $clog2(BurstDataCount + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(BurstDataCount - 1);

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            owner_q, owner_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]            ptr_q, ptr_d;
  logic [AddressBitWidth-1:0] addr_q, addr_d;
  logic                       cmd_q, cmd_d;

  logic [IdxW-1:0]            winner;
  logic                       any_valid;
  logic                       accept;
  logic [IdxW-1:0]            sel;

  rr_picker #(
    .NumRequesters (NumRequesters),
    .IdxW          (IdxW)
  ) u_picker (
    .req_i       (req_cmd_en),
    .ptr_i       (ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  assign accept = (state_q == IDLE) && !br_busy && any_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      cmd_q   <= CMD_READ;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
    end
  end

  // The accept cycle already carries the first write beat, so a write burst
  // continues from count 1; a read counts returned beats from 0.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = winner;
          ptr_d   = (winner == IdxW'(NumRequesters - 1)) ? '0 : winner + IdxW'(1);
          addr_d  = req_addr[winner];
          cmd_d   = req_cmd[winner];
          if (req_cmd[winner] == CMD_WRITE) begin
            if (BurstDataCount > 1) begin
              state_d = WRITE_BURST;
              cnt_d   = CntW'(1);
            end
          end else begin
            state_d = READ_BURST;
            cnt_d   = '0;
          end
        end
      end
      WRITE_BURST: begin
        if (cnt_q == LastBeat) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      READ_BURST: begin
        if (br_rd_data_valid) begin
          if (cnt_q == LastBeat) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel               = accept ? winner : owner_q;
    br_cmd_en         = accept;
    br_cmd            = accept ? req_cmd[winner] : cmd_q;
    br_addr           = accept ? req_addr[winner] : addr_q;
    br_wr_data        = req_wr_data[sel];
    br_data_mask      = req_data_mask[sel];
    req_rd_data       = br_rd_data;
    grant             = '0;
    req_rd_data_valid = '0;
    req_busy          = '0;
    if (accept || (state_q != IDLE)) begin
      grant[sel] = 1'b1;
    end
    if ((state_q == READ_BURST) && br_rd_data_valid) begin
      req_rd_data_valid[owner_q] = 1'b1;
    end
    for (int i = 0; i < NumRequesters; i++) begin
      req_busy[i] = br_busy || (state_q != IDLE) || !any_valid || (winner != IdxW'(i));
    end
  end

endmodule
